// File: rtl/matrix_multiply_param_mac_pkg.sv
// Shared FSM encoding and width helpers for the lane-parallel matrix multiplier.
package matrix_multiply_param_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Never returns zero so single-value counters still get a 1-bit register.
    function automatic int safe_clog2(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    function automatic int acc_width(input int data_w, input int dim);
        return 2 * data_w + $clog2(dim);
    endfunction

    function automatic int a_addr_width(input int dim);
        return safe_clog2(dim * dim);
    endfunction

    function automatic int grp_addr_width(input int dim, input int lanes);
        return safe_clog2(dim * dim / lanes);
    endfunction

endpackage

// File: rtl/matrix_multiply_param_mac_mac_unit.sv
// One MAC lane: DATA_W x DATA_W product, sign/zero extended, loaded or accumulated.
// One-cycle update when en_i is high; load_i starts a new dot product.
module mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              load_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [ACC_W-1:0]  acc_o
);

    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] prod;
    logic [ACC_W-1:0] acc_q;

    // Modulo-2^ACC_W multiply of extended operands yields the exact two's-complement product.
    assign a_ext = {{(ACC_W-DATA_W){signed_i & a_i[DATA_W-1]}}, a_i};
    assign b_ext = {{(ACC_W-DATA_W){signed_i & b_i[DATA_W-1]}}, b_i};
    assign prod  = a_ext * b_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= load_i ? prod : acc_q + prod;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/matrix_multiply_param_mac.sv
// DIM x DIM matrix multiply, LANES output columns per issue, k innermost.
// Issue -> fetch -> accumulate pipeline; one C group written every DIM cycles.
module matrix_multiply_param_mac
    import matrix_multiply_param_mac_pkg::*;
#(
    parameter  int DIM    = 8,
    parameter  int DATA_W = 8,
    parameter  int LANES  = 8,
    localparam int ACC_W  = acc_width(DATA_W, DIM),
    localparam int AW     = a_addr_width(DIM),
    localparam int GW     = grp_addr_width(DIM, LANES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    signed_mode,
    output logic [AW-1:0]           a_addr,
    input  logic [DATA_W-1:0]       a_rdata,
    output logic [GW-1:0]           b_addr,
    input  logic [LANES*DATA_W-1:0] b_rdata,
    output logic                    c_wr_en,
    output logic [GW-1:0]           c_wr_addr,
    output logic [LANES*ACC_W-1:0]  c_wr_data,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             cycle_count
);

    localparam int GPR = DIM / LANES;
    localparam int KW  = safe_clog2(DIM);
    localparam int CW  = safe_clog2(GPR);

    if (DIM % LANES != 0) begin : g_bad_lanes
        $error("matrix_multiply_param_mac: LANES must divide DIM");
    end

    state_t          state_q;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   row_q;
    logic [CW-1:0]   cg_q;
    logic            signed_q;
    logic            busy_q;
    logic            done_q;
    logic [15:0]     cyc_q;

    logic            issue;
    logic            last_k;
    logic            last_cg;
    logic            last_row;
    logic            last_issue;
    logic [AW-1:0]   a_addr_d;
    logic [GW-1:0]   b_addr_d;
    logic [GW-1:0]   grp_d;

    logic            f_vld_q;
    logic            f_k0_q;
    logic            f_klast_q;
    logic            f_last_q;
    logic [GW-1:0]   f_grp_q;
    logic            wr_en_q;
    logic            w_last_q;
    logic [GW-1:0]   wr_addr_q;

    assign issue      = (state_q == ST_RUN);
    assign last_k     = (int'(k_q) == DIM - 1);
    assign last_cg    = (int'(cg_q) == GPR - 1);
    assign last_row   = (int'(row_q) == DIM - 1);
    assign last_issue = last_k && last_cg && last_row;

    assign a_addr_d = issue ? AW'(int'(row_q) * DIM + int'(k_q)) : '0;
    assign b_addr_d = issue ? GW'(int'(k_q) * GPR + int'(cg_q)) : '0;
    assign grp_d    = GW'(int'(row_q) * GPR + int'(cg_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            cg_q     <= '0;
            row_q    <= '0;
            signed_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cyc_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q  <= ST_RUN;
                        busy_q   <= 1'b1;
                        cyc_q    <= '0;
                        signed_q <= signed_mode;
                        k_q      <= '0;
                        cg_q     <= '0;
                        row_q    <= '0;
                    end
                end
                ST_RUN: begin
                    cyc_q <= cyc_q + 16'd1;
                    if (!last_k) begin
                        k_q <= k_q + KW'(1);
                    end else begin
                        k_q <= '0;
                        if (!last_cg) begin
                            cg_q <= cg_q + CW'(1);
                        end else begin
                            cg_q <= '0;
                            if (!last_row) begin
                                row_q <= row_q + KW'(1);
                            end else begin
                                row_q   <= '0;
                                state_q <= ST_DRAIN;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    cyc_q <= cyc_q + 16'd1;
                    if (wr_en_q && w_last_q) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Fetch and write stages only carry control; data sits in the lane accumulators.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_vld_q   <= 1'b0;
            f_k0_q    <= 1'b0;
            f_klast_q <= 1'b0;
            f_last_q  <= 1'b0;
            f_grp_q   <= '0;
            wr_en_q   <= 1'b0;
            w_last_q  <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            f_vld_q   <= issue;
            f_k0_q    <= (k_q == '0);
            f_klast_q <= last_k;
            f_last_q  <= issue && last_issue;
            f_grp_q   <= grp_d;
            wr_en_q   <= f_vld_q && f_klast_q;
            w_last_q  <= f_vld_q && f_last_q;
            wr_addr_q <= f_grp_q;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [ACC_W-1:0] acc;

        mac_unit #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_mac (
            .clk      (clk),
            .reset    (reset),
            .en_i     (f_vld_q),
            .load_i   (f_k0_q),
            .signed_i (signed_q),
            .a_i      (a_rdata),
            .b_i      (b_rdata[l*DATA_W +: DATA_W]),
            .acc_o    (acc)
        );

        assign c_wr_data[l*ACC_W +: ACC_W] = acc;
    end

    assign a_addr      = a_addr_d;
    assign b_addr      = b_addr_d;
    assign c_wr_en     = wr_en_q;
    assign c_wr_addr   = wr_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cycle_count = cyc_q;

endmodule

// File: tb/tb_matrix_multiply_param_mac.sv
// Bench for matrix_multiply_param_mac: default instance plus a LANES=2 instance
// sharing one A/B memory, checked against a plain triple-loop matrix product.
module tb_matrix_multiply_param_mac;

    logic         clk = 1'b0;
    logic         reset;
    logic         start0, start1;
    logic         sm0, sm1;

    logic [5:0]   a_addr0, a_addr1;
    logic [7:0]   a_rd0, a_rd1;
    logic [2:0]   b_addr0, c_wr_addr0;
    logic [4:0]   b_addr1, c_wr_addr1;
    logic [63:0]  b_rd0;
    logic [15:0]  b_rd1;
    logic [151:0] c_wr_data0;
    logic [37:0]  c_wr_data1;
    logic         c_wr_en0, c_wr_en1, busy0, busy1, done0, done1;
    logic [15:0]  cc0, cc1;

    logic [7:0]   A [64];
    logic [7:0]   B [64];
    logic [18:0]  got [64];
    logic [18:0]  exp_c [64];

    int tests = 0;
    int fails = 0;
    int r_busy, r_wr, r_done, r_gap, r_bad;
    bit r_tout;

    always #5 clk = ~clk;

    matrix_multiply_param_mac dut0 (
        .clk(clk), .reset(reset), .start(start0), .signed_mode(sm0),
        .a_addr(a_addr0), .a_rdata(a_rd0), .b_addr(b_addr0), .b_rdata(b_rd0),
        .c_wr_en(c_wr_en0), .c_wr_addr(c_wr_addr0), .c_wr_data(c_wr_data0),
        .busy(busy0), .done(done0), .cycle_count(cc0)
    );

    matrix_multiply_param_mac #(.DIM(8), .DATA_W(8), .LANES(2)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .signed_mode(sm1),
        .a_addr(a_addr1), .a_rdata(a_rd1), .b_addr(b_addr1), .b_rdata(b_rd1),
        .c_wr_en(c_wr_en1), .c_wr_addr(c_wr_addr1), .c_wr_data(c_wr_data1),
        .busy(busy1), .done(done1), .cycle_count(cc1)
    );

    // Synchronous memories: data valid the cycle after the address.
    always @(posedge clk) begin
        a_rd0 <= A[a_addr0];
        a_rd1 <= A[a_addr1];
        for (int l = 0; l < 8; l++)
            b_rd0[l*8 +: 8] <= B[int'(b_addr0) * 8 + l];
        for (int l = 0; l < 2; l++)
            b_rd1[l*8 +: 8] <= B[(int'(b_addr1) / 4) * 8 + (int'(b_addr1) % 4) * 2 + l];
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit sgn);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                longint acc = 0;
                for (int k = 0; k < 8; k++) begin
                    longint av = sgn ? longint'($signed(A[i*8+k])) : longint'(A[i*8+k]);
                    longint bv = sgn ? longint'($signed(B[k*8+j])) : longint'(B[k*8+j]);
                    acc += av * bv;
                end
                exp_c[i*8+j] = acc[18:0];
            end
    endtask

    // mode 0: plain run; 1: extra start + signed_mode flip at busy cycle 10; 2: reset at busy cycle 20.
    task automatic run(input int inst, input bit sgn, input int mode);
        int  last_w, post, wa;
        bit  b, d, we;
        r_busy = 0; r_wr = 0; r_done = 0; r_gap = -1; r_bad = 0; r_tout = 1;
        last_w = -100; post = 0;
        @(negedge clk);
        if (inst == 0) begin start0 = 1'b1; sm0 = sgn; end
        else begin start1 = 1'b1; sm1 = sgn; end
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (c == 1) begin start0 = 1'b0; start1 = 1'b0; end
            if (mode == 1 && c == 10) begin start0 = 1'b1; sm0 = !sgn; end
            if (mode == 1 && c == 11) start0 = 1'b0;
            if (mode == 2 && c == 21) begin
                check("rst_busy_drop", busy0, 0);
                check("rst_wr_drop", c_wr_en0, 0);
                reset = 1'b0;
            end
            if (inst == 0) begin b = busy0; d = done0; we = c_wr_en0; wa = int'(c_wr_addr0); end
            else begin b = busy1; d = done1; we = c_wr_en1; wa = int'(c_wr_addr1); end
            if (b) r_busy++;
            if (we) begin
                if (wa != r_wr) r_bad++;
                if (inst == 0) for (int l = 0; l < 8; l++) got[wa*8+l] = c_wr_data0[l*19 +: 19];
                else for (int l = 0; l < 2; l++) got[wa*2+l] = c_wr_data1[l*19 +: 19];
                r_wr++;
                last_w = c;
            end
            if (d) begin r_done++; r_gap = c - last_w; end
            if (mode == 2 && c == 20) reset = 1'b1;
            if (r_done > 0 || (mode == 2 && c >= 120)) begin
                r_tout = 0;
                post++;
                if (post == 3) break;
            end
        end
    endtask

    task automatic verify(input string tag, input int expw, input int expcc, input longint cc);
        check({tag, "_timeout"}, r_tout, 0);
        check({tag, "_writes"}, r_wr, expw);
        check({tag, "_order"}, r_bad, 0);
        check({tag, "_done_pulses"}, r_done, 1);
        check({tag, "_done_gap"}, r_gap, 1);
        check({tag, "_busy_cycles"}, r_busy, expcc);
        check({tag, "_cycle_count"}, cc, expcc);
        for (int i = 0; i < 64; i++) check({tag, "_c"}, got[i], exp_c[i]);
    endtask

    task automatic load_identity();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                A[i*8+j] = (i == j) ? 8'd1 : 8'd0;
                B[i*8+j] = 8'(i * 8 + j);
            end
    endtask

    task automatic load_random();
        for (int i = 0; i < 64; i++) begin
            A[i] = 8'($urandom_range(0, 255));
            B[i] = 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0; sm0 = 1'b0; sm1 = 1'b0;
        for (int i = 0; i < 64; i++) begin A[i] = '0; B[i] = '0; got[i] = '0; end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", busy0, 0);
        check("reset_done", done0, 0);
        check("reset_wr_en", c_wr_en0, 0);
        check("reset_cycle_count", cc0, 0);
        check("reset_a_addr", a_addr0, 0);
        check("reset_b_addr", b_addr0, 0);

        load_identity(); model(1'b1);
        run(0, 1'b1, 0);
        verify("ident", 8, 66, cc0);
        for (int i = 0; i < 64; i++) check("ident_eq_b", got[i], longint'(B[i]));
        repeat (4) @(negedge clk);
        check("idle_a_addr", a_addr0, 0);
        check("idle_b_addr", b_addr0, 0);
        check("cc_hold", cc0, 66);

        for (int i = 0; i < 64; i++) begin A[i] = 8'h80; B[i] = 8'h80; end
        model(1'b1);
        run(0, 1'b1, 0);
        verify("neg128", 8, 66, cc0);
        check("neg128_lit", got[5], 131072);

        for (int i = 0; i < 64; i++) begin A[i] = 8'hFF; B[i] = 8'hFF; end
        model(1'b0);
        run(0, 1'b0, 0);
        verify("u255", 8, 66, cc0);
        check("u255_lit", got[63], 520200);

        load_random(); model(1'b1);
        run(0, 1'b1, 0);
        verify("rand_s", 8, 66, cc0);

        load_random(); model(1'b0);
        run(0, 1'b0, 0);
        verify("rand_u", 8, 66, cc0);

        load_random(); model(1'b1);
        run(1, 1'b1, 0);
        verify("lanes2", 32, 258, cc1);

        load_identity(); model(1'b1);
        run(0, 1'b1, 1);
        verify("restart_ign", 8, 66, cc0);

        run(0, 1'b1, 2);
        check("abort_timeout", r_tout, 0);
        check("abort_writes", r_wr, 2);
        check("abort_done", r_done, 0);
        check("abort_busy_idle", busy0, 0);
        for (int i = 0; i < 64; i++) got[i] = '0;
        run(0, 1'b1, 0);
        verify("after_abort", 8, 66, cc0);

        @(negedge clk);
        reset = 1'b1; start0 = 1'b1;
        @(negedge clk);
        check("rst_prio_busy", busy0, 0);
        reset = 1'b0; start0 = 1'b0;
        @(negedge clk);
        check("rst_prio_idle", busy0, 0);
        check("rst_prio_cc", cc0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matrix_multiply_param_mac.md
MATRIX_MULTIPLY_PARAM_MAC -- requirements
Module: matrix_multiply_param_mac

Interface
REQ-001 Parameter DIM, default 8: matrix dimension. A, B and C are DIM x DIM, stored row-major.
REQ-002 Parameter DATA_W, default 8: element width of A and B.
REQ-003 Parameter LANES, default 8: number of parallel MAC lanes; LANES SHALL divide DIM.
REQ-004 Derived constant ACC_W = 2*DATA_W + clog2(DIM): accumulator/result width (19 at defaults).
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  level, sampled in IDLE only; begins one full multiply.
REQ-008 signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; latched at start.
REQ-009 a_addr  out  clog2(DIM*DIM)  A element address = row*DIM + k.
REQ-010 a_rdata  in  DATA_W  A element; valid one cycle after a_addr.
REQ-011 b_addr  out  clog2(DIM*DIM/LANES)  B lane-group address = k*(DIM/LANES) + col_group.
REQ-012 b_rdata  in  LANES*DATA_W  B[k][col_group*LANES + l] on slice l; valid one cycle after b_addr.
REQ-013 c_wr_en  out  1  one-cycle write strobe.
REQ-014 c_wr_addr  out  clog2(DIM*DIM/LANES)  C group address = row*(DIM/LANES) + col_group.
REQ-015 c_wr_data  out  LANES*ACC_W  slice l = C[row][col_group*LANES + l].
REQ-016 busy  out  1  high from the cycle after start is accepted through the last c_wr_en cycle.
REQ-017 done  out  1  one-cycle pulse in the cycle after the last c_wr_en.
REQ-018 cycle_count  out  16  number of busy cycles of the last run; holds until the next start.

Function
REQ-019 FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE->RUN on start.
- RUN->DRAIN after the last issue.
- DRAIN->DONE after the last write.
- DONE->IDLE unconditionally after one cycle.
REQ-020 Each RUN cycle issues one (row, col_group, k) triple; k is innermost, then col_group, then row. Issue order is strictly sequential with no bubbles; G = DIM*DIM/LANES groups, G*DIM issue cycles in total.
REQ-021 Datapath is a three-stage pipeline: issue (addresses), fetch (rdata valid), accumulate (acc registered at end of the fetch cycle).
REQ-022 On k == 0 a lane SHALL load acc <= product, otherwise acc <= acc + product. No clear bubble is needed between groups.
REQ-023 Product: DATA_W x DATA_W. It is signed or unsigned per the latched signed_mode and extended to ACC_W by sign- or zero-extension to match. No overflow is possible; no saturation.
REQ-024 c_wr_en SHALL assert in the cycle after the k == DIM-1 accumulate, carrying that group's results on c_wr_data/c_wr_addr. Consecutive groups write every DIM cycles.
REQ-025 Cycle budget: first issue in busy cycle 1; last write in busy cycle G*DIM+2; done in the following cycle; cycle_count = G*DIM+2 (66 at defaults).
REQ-026 start while busy or done is ignored. signed_mode changes while busy have no effect.
REQ-027 a_addr/b_addr SHALL hold 0 outside RUN. c_wr_data is don't-care when c_wr_en = 0.
REQ-028 DIM == LANES (single group per row) and LANES == 1 SHALL both operate without special casing.

Reset
REQ-029 reset SHALL force state IDLE and clear busy, done, c_wr_en, counters and accumulators to 0 at the next edge. cycle_count is cleared to 0.
REQ-030 reset mid-run SHALL abort the run: no further c_wr_en and no done pulse. The next start begins a fresh run.
REQ-031 reset has priority over start in the same cycle.

Structure
REQ-032 Shared package holds the FSM state encoding and the clog2-based width functions (ACC_W and address widths).
REQ-033 One sub-module, mac_unit (DATA_W, ACC_W, signed select, load/accumulate control), instantiated LANES times via generate.
REQ-034 An elaboration-time check SHALL fail if DIM % LANES != 0.

Verification
REQ-035 Defaults, A = identity, B[i][j] = i*8+j, signed -> C == B; 8 writes; cycle_count = 66; done 1 cycle after the last write.
REQ-036 Defaults, signed, all A = B = -128 -> every C element = 131072 (fits 19-bit signed).
REQ-037 Defaults, unsigned, all A = B = 255 -> every C element = 520200.
REQ-038 LANES = 2, random signed data vs. golden model -> 32 writes, all match; cycle_count = 258.
REQ-039 start re-asserted at busy cycle 10 -> ignored; results and cycle count identical to REQ-035.
REQ-040 reset at busy cycle 20 -> busy/c_wr_en drop next cycle, no done pulse; a subsequent start yields the REQ-035 results.
